// File: rtl/tri_sram_router_pkg.sv
// Shared types for the triple-buffer controller and the SRAM router:
// buffer IDs, selection codes, and the code -> (camera, VGA) buffer decode.
package tri_sram_router_pkg;

  localparam int FRAME_WORDS_DEF = 76800;

  typedef enum logic [1:0] {BUF_X = 2'd0, BUF_Y = 2'd1, BUF_Z = 2'd2} buf_id_e;

  typedef enum logic [2:0] {
    SEL_A = 3'd0, SEL_B = 3'd1, SEL_C = 3'd2,
    SEL_D = 3'd3, SEL_E = 3'd4, SEL_F = 3'd5
  } sel_code_e;

  typedef struct packed {
    buf_id_e cam;
    buf_id_e vga;
    logic    ok;
  } sel_map_t;

  // Codes 6/7 come back with ok=0 so callers can hold their mapping.
  function automatic sel_map_t decode_sel(input logic [2:0] code);
    sel_map_t m;
    m = '{cam: BUF_X, vga: BUF_Y, ok: 1'b1};
    case (code)
      SEL_A:   begin m.cam = BUF_X; m.vga = BUF_Y; end
      SEL_B:   begin m.cam = BUF_X; m.vga = BUF_Z; end
      SEL_C:   begin m.cam = BUF_Y; m.vga = BUF_X; end
      SEL_D:   begin m.cam = BUF_Y; m.vga = BUF_Z; end
      SEL_E:   begin m.cam = BUF_Z; m.vga = BUF_X; end
      SEL_F:   begin m.cam = BUF_Z; m.vga = BUF_Y; end
      default: m.ok = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tri_frame_addr_gen.sv
// Frame address counter: cleared while in the frame gap, steps on each
// accepted strobe, then either saturates at FRAME_WORDS (sticky overflow) or wraps.
module tri_frame_addr_gen #(
  parameter int ADDR_W      = 17,
  parameter int FRAME_WORDS = 76800,
  parameter bit WRAP        = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gap,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              fire,
  output logic              overflow
);

  // One extra bit so the saturated value FRAME_WORDS is representable
  // even when FRAME_WORDS == 2**ADDR_W.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FRAME_WORDS);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(FRAME_WORDS - 1);

  logic [ADDR_W:0] cnt;

  assign fire = !gap && step && (cnt < LIMIT);
  assign addr = cnt[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (gap) begin
      cnt <= '0;
    end else if (fire) begin
      cnt <= (WRAP && cnt == LAST) ? '0 : cnt + 1'b1;
    end else if (step) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/tri_sram_router.sv
// Routes the camera write stream and the VGA read stream onto three
// single-port SRAMs, freezing each stream's buffer mapping for its whole frame.
module tri_sram_router
  import tri_sram_router_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 12,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          sram_select,
  input  logic                cam_vsync,
  input  logic                cam_valid,
  input  logic [DATA_W-1:0]   cam_data,
  input  logic                vga_vsync,
  input  logic                vga_req,
  output logic [DATA_W-1:0]   vga_data,
  output logic                vga_valid,
  output logic [3*ADDR_W-1:0] sram_addr,
  output logic [3*DATA_W-1:0] sram_wdata,
  output logic [2:0]          sram_we,
  output logic [2:0]          sram_re,
  input  logic [3*DATA_W-1:0] sram_rdata,
  output logic                cam_overflow,
  output logic                sel_error,
  output logic                collision
);

  sel_map_t          dec;
  buf_id_e           cam_map, vga_map;
  logic [ADDR_W-1:0] cam_addr, vga_addr;
  logic              cam_fire, vga_fire, cam_ovf, vga_ovf, coll_now;
  logic [2:1]        vld_pipe, hit_pipe;
  buf_id_e           rd_buf1, rd_buf2;
  logic [DATA_W-1:0] rdata_sel;

  assign dec = decode_sel(sram_select);

  tri_frame_addr_gen #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .WRAP(1'b0)) u_cam_addr (
    .clk(clk), .reset(reset), .gap(cam_vsync), .step(cam_valid),
    .addr(cam_addr), .fire(cam_fire), .overflow(cam_ovf)
  );

  tri_frame_addr_gen #(.ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS), .WRAP(1'b1)) u_vga_addr (
    .clk(clk), .reset(reset), .gap(!vga_vsync), .step(vga_req),
    .addr(vga_addr), .fire(vga_fire), .overflow(vga_ovf)
  );

  // A wrap-mode generator never refuses a step, so vga_ovf is constantly 0.
  assign cam_overflow = cam_ovf | vga_ovf;

  // Maps only follow the controller during their own stream's gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cam_map   <= BUF_X;
      vga_map   <= BUF_Y;
      sel_error <= 1'b0;
    end else if (!dec.ok) begin
      sel_error <= 1'b1;
    end else begin
      if (cam_vsync)  cam_map <= dec.cam;
      if (!vga_vsync) vga_map <= dec.vga;
    end
  end

  // Writes win a shared buffer; the read is dropped but still returns a slot.
  assign coll_now = vga_fire && (cam_map == vga_map);

  always_comb begin
    rdata_sel = '0;
    case (rd_buf2)
      BUF_X:   rdata_sel = sram_rdata[0*DATA_W +: DATA_W];
      BUF_Y:   rdata_sel = sram_rdata[1*DATA_W +: DATA_W];
      BUF_Z:   rdata_sel = sram_rdata[2*DATA_W +: DATA_W];
      default: rdata_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_we    <= '0;
      sram_re    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      collision  <= 1'b0;
      vld_pipe   <= '0;
      hit_pipe   <= '0;
      rd_buf1    <= BUF_X;
      rd_buf2    <= BUF_X;
      vga_valid  <= 1'b0;
      vga_data   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sram_we[i] <= cam_fire && (cam_map == buf_id_e'(i));
        sram_re[i] <= vga_fire && !coll_now && (vga_map == buf_id_e'(i));
        sram_wdata[i*DATA_W +: DATA_W] <= (cam_fire && cam_map == buf_id_e'(i)) ? cam_data : '0;
        if (cam_fire && cam_map == buf_id_e'(i))
          sram_addr[i*ADDR_W +: ADDR_W] <= cam_addr;
        else if (vga_fire && !coll_now && vga_map == buf_id_e'(i))
          sram_addr[i*ADDR_W +: ADDR_W] <= vga_addr;
        else
          sram_addr[i*ADDR_W +: ADDR_W] <= '0;
      end
      collision   <= coll_now;
      vld_pipe[1] <= vga_fire;
      vld_pipe[2] <= vld_pipe[1];
      hit_pipe[1] <= vga_fire && !coll_now;
      hit_pipe[2] <= hit_pipe[1];
      rd_buf1     <= vga_map;
      rd_buf2     <= rd_buf1;
      vga_valid   <= vld_pipe[2];
      if (vld_pipe[2]) vga_data <= hit_pipe[2] ? rdata_sel : '0;
    end
  end

endmodule

// File: tb/tb_tri_sram_router.sv
// Directed bench for tri_sram_router with a 4-word frame so saturation and
// wrap boundaries are reachable in a few cycles.
module tb_tri_sram_router;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int FW = 4;

  logic            clk, reset;
  logic [2:0]      sram_select;
  logic            cam_vsync, cam_valid, vga_vsync, vga_req;
  logic [DW-1:0]   cam_data, vga_data;
  logic            vga_valid, cam_overflow, sel_error, collision;
  logic [3*AW-1:0] sram_addr;
  logic [3*DW-1:0] sram_wdata, sram_rdata;
  logic [2:0]      sram_we, sram_re;

  int vectors = 0;
  int errs    = 0;

  tri_sram_router #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .sram_select(sram_select),
    .cam_vsync(cam_vsync), .cam_valid(cam_valid), .cam_data(cam_data),
    .vga_vsync(vga_vsync), .vga_req(vga_req),
    .vga_data(vga_data), .vga_valid(vga_valid),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata),
    .cam_overflow(cam_overflow), .sel_error(sel_error), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] addr_at(input int b, input int a);
    logic [63:0] v;
    v = 64'(a);
    return v << (AW * b);
  endfunction

  function automatic logic [63:0] data_at(input int b, input logic [DW-1:0] d);
    logic [63:0] v;
    v = 64'(d);
    return v << (DW * b);
  endfunction

  initial begin
    reset = 1'b1; sram_select = 3'd0; cam_vsync = 1'b1; cam_valid = 1'b0;
    cam_data = '0; vga_vsync = 1'b0; vga_req = 1'b0; sram_rdata = '0;
    tick(); tick();
    chk("rst_we", 64'(sram_we), 64'h0);
    chk("rst_re", 64'(sram_re), 64'h0);
    chk("rst_addr", 64'(sram_addr), 64'h0);
    chk("rst_vvalid", 64'(vga_valid), 64'h0);
    chk("rst_flags", {61'h0, cam_overflow, sel_error, collision}, 64'h0);

    // Three camera pixels into X
    reset = 1'b0; tick();
    cam_vsync = 1'b0;
    cam_valid = 1'b1; cam_data = 12'h111; tick();
    chk("w0_we", 64'(sram_we), 64'h1);
    chk("w0_addr", 64'(sram_addr), addr_at(0, 0));
    chk("w0_data", 64'(sram_wdata), data_at(0, 12'h111));
    cam_data = 12'h222; tick();
    chk("w1_addr", 64'(sram_addr), addr_at(0, 1));
    chk("w1_data", 64'(sram_wdata), data_at(0, 12'h222));
    cam_data = 12'h333; tick();
    chk("w2_we", 64'(sram_we), 64'h1);
    chk("w2_addr", 64'(sram_addr), addr_at(0, 2));
    chk("w2_data", 64'(sram_wdata), data_at(0, 12'h333));
    cam_valid = 1'b0; tick();
    chk("w_idle_we", 64'(sram_we), 64'h0);

    // Read from Z with a 3-cycle return
    sram_select = 3'd3; vga_vsync = 1'b0; tick();
    vga_vsync = 1'b1; vga_req = 1'b1; tick();
    chk("r_re", 64'(sram_re), 64'h4);
    chk("r_addr", 64'(sram_addr), addr_at(2, 0));
    vga_req = 1'b0; tick();
    chk("r_n2_valid", 64'(vga_valid), 64'h0);
    sram_rdata = 36'(data_at(2, 12'hABC)); tick();
    chk("r_n3_valid", 64'(vga_valid), 64'h1);
    chk("r_n3_data", 64'(vga_data), 64'hABC);
    sram_rdata = '0; tick();
    chk("r_after_valid", 64'(vga_valid), 64'h0);
    chk("r_hold_data", 64'(vga_data), 64'hABC);

    // Select change mid camera frame does not move writes until the gap
    sram_select = 3'd0; cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; cam_valid = 1'b1; cam_data = 12'h444; tick();
    chk("fz0_addr", 64'(sram_addr), addr_at(0, 0));
    sram_select = 3'd4; cam_data = 12'h555; tick();
    chk("fz1_we", 64'(sram_we), 64'h1);
    chk("fz1_addr", 64'(sram_addr), addr_at(0, 1));
    cam_vsync = 1'b1; tick();
    chk("gap_strobe_we", 64'(sram_we), 64'h0);
    cam_vsync = 1'b0; cam_data = 12'h666; tick();
    chk("nf_we", 64'(sram_we), 64'h4);
    chk("nf_addr", 64'(sram_addr), addr_at(2, 0));
    chk("nf_data", 64'(sram_wdata), data_at(2, 12'h666));
    cam_valid = 1'b0;

    // Five pixels in a four-word frame
    sram_select = 3'd0; cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; cam_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cam_data = 12'(12'h100 + i); tick();
      chk("ov_we", 64'(sram_we), 64'h1);
      chk("ov_addr", 64'(sram_addr), addr_at(0, i));
    end
    chk("ov_before", 64'(cam_overflow), 64'h0);
    cam_data = 12'h1FF; tick();
    chk("ov_drop_we", 64'(sram_we), 64'h0);
    chk("ov_flag", 64'(cam_overflow), 64'h1);
    cam_valid = 1'b0; cam_vsync = 1'b1; tick();
    chk("ov_sticky", 64'(cam_overflow), 64'h1);

    // Invalid select in both gaps keeps X/Y
    sram_select = 3'd0; vga_vsync = 1'b0; tick();
    sram_select = 3'd7; tick();
    chk("sel_err", 64'(sel_error), 64'h1);
    cam_vsync = 1'b0; vga_vsync = 1'b1; cam_valid = 1'b1; vga_req = 1'b1;
    cam_data = 12'h777; tick();
    chk("se_we", 64'(sram_we), 64'h1);
    chk("se_re", 64'(sram_re), 64'h2);
    chk("se_addr", 64'(sram_addr), 64'h0);
    chk("se_coll", 64'(collision), 64'h0);
    cam_valid = 1'b0; vga_req = 1'b0; tick();
    sram_rdata = 36'(data_at(1, 12'h5A5)); tick();
    chk("se_rvalid", 64'(vga_valid), 64'h1);
    chk("se_rdata", 64'(vga_data), 64'h5A5);
    sram_rdata = '0;

    // VGA frozen on X, camera refreshed onto X
    sram_select = 3'd2; vga_vsync = 1'b0; tick();
    vga_vsync = 1'b1; sram_select = 3'd0; cam_vsync = 1'b1; tick();
    cam_vsync = 1'b0; cam_valid = 1'b1; vga_req = 1'b1; cam_data = 12'h999;
    sram_rdata = 36'(data_at(0, 12'hFFF)); tick();
    chk("co_we", 64'(sram_we), 64'h1);
    chk("co_re", 64'(sram_re), 64'h0);
    chk("co_pulse", 64'(collision), 64'h1);
    chk("co_data", 64'(sram_wdata), data_at(0, 12'h999));
    cam_valid = 1'b0; vga_req = 1'b0; tick();
    chk("co_pulse_end", 64'(collision), 64'h0);
    tick();
    chk("co_valid", 64'(vga_valid), 64'h1);
    chk("co_zero", 64'(vga_data), 64'h0);
    sram_rdata = '0;

    // VGA address wraps after FRAME_WORDS-1
    vga_vsync = 1'b0; tick();
    vga_vsync = 1'b1; vga_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wr_re", 64'(sram_re), 64'h2);
      chk("wr_addr", 64'(sram_addr), addr_at(1, i % FW));
    end
    vga_req = 1'b0;
    tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
